// File: rtl/imem_serial_loader.sv
// Loads a length-prefixed, big-endian word stream into instruction memory and
// keeps the CPU in reset until the whole image has been written.
module imem_serial_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int          WIDX_W  = $clog2(DEPTH + 1);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         shift_q, shift_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                rx_fire;
    logic [15:0]         len_full;
    logic [15:0]         word_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Outputs are decoded purely from the state register (Moore).
    assign rx_ready_o   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
    assign busy_o       = rx_ready_o || (state_q == S_WRITE);
    assign imem_we_o    = (state_q == S_WRITE);
    assign done_o       = (state_q == S_DONE);
    assign cpu_rst_n_o  = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;

    assign rx_fire   = rx_valid_i && rx_ready_o;
    assign len_full  = {len_q[15:8], rx_data_i};
    assign word_next = {{(16 - WIDX_W){1'b0}}, word_idx_q} + 16'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_fire) begin
                    len_d[15:8] = rx_data_i;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_fire) begin
                    len_d[7:0] = rx_data_i;
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if (len_full > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_DATA;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    shift_d    = {shift_q[23:0], rx_data_i};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Latch address/data on the 4th byte so they hold after the strobe.
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = ADDR_W'(word_idx_q) << 2;
                        wdata_d = {shift_q[23:0], rx_data_i};
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (word_next == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_serial_loader.sv
// Directed bench for imem_serial_loader: expected IMEM writes are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_imem_serial_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        cpu_rst_n_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int          checks = 0;
    int          fails  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [7:0]  stream[$];

    imem_serial_loader #(.DEPTH(32), .ADDR_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_wdata_o(imem_wdata_o),
        .cpu_rst_n_o (cpu_rst_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the head of the queue.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && imem_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                         imem_addr_o, imem_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", imem_addr_o, mon_e[63:32]);
                check("wr_data", imem_wdata_o, mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  go;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        n  = 0;
        go = 1'b0;
        while (!go) begin
            @(negedge clk_i);
            if (rx_ready_o) go = 1'b1;
            else begin
                n++;
                if (n > 50) begin
                    checks++;
                    fails++;
                    $display("FAIL rx_timeout: byte 0x%02h not accepted, expected accept", b);
                    go = 1'b1;
                end
            end
        end
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic send_stream(input int gap_max);
        foreach (stream[i]) begin
            send_byte(stream[i]);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic load_case1(input int gap_max);
        exp_q.push_back({32'h0000_0000, 32'h8C01_0000});
        exp_q.push_back({32'h0000_0004, 32'h0022_0820});
        stream = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h22, 8'h08, 8'h20};
        send_stream(gap_max);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done_o || err_o) && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        start_i    = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;

        // Reset state
        #2;
        check("rst_flags", {imem_we_o, rx_ready_o, cpu_rst_n_o, busy_o, done_o, err_o}, 0);
        check("rst_addr", imem_addr_o, 0);
        check("rst_wdata", imem_wdata_o, 0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("idle_flags", {imem_we_o, rx_ready_o, cpu_rst_n_o, busy_o, done_o, err_o}, 0);

        // Case 1: back-to-back stream
        pulse_start();
        check("c1_busy", busy_o, 1);
        check("c1_ready", rx_ready_o, 1);
        load_case1(0);
        check("c1_we_after_4th", imem_we_o, 1);
        tick();
        check("c1_done", done_o, 1);
        check("c1_cpu_rst_n", cpu_rst_n_o, 1);
        check("c1_busy_off", busy_o, 0);
        check("c1_queue", exp_q.size(), 0);

        // Case 2: zero-length image
        pulse_start();
        check("c2_done_cleared", done_o, 0);
        check("c2_cpu_held", cpu_rst_n_o, 0);
        stream = '{8'h00, 8'h00};
        send_stream(0);
        check("c2_done", done_o, 1);
        check("c2_cpu_rst_n", cpu_rst_n_o, 1);
        repeat (3) tick();

        // Case 3: LEN = DEPTH + 1 errors out, then a valid reload
        pulse_start();
        stream = '{8'h00, 8'h21};
        send_stream(0);
        check("c3_err", err_o, 1);
        check("c3_ready", rx_ready_o, 0);
        check("c3_cpu_held", cpu_rst_n_o, 0);
        check("c3_done", done_o, 0);
        repeat (3) tick();
        check("c3_err_hold", err_o, 1);
        pulse_start();
        check("c3_err_clr", err_o, 0);
        load_case1(0);
        tick();
        check("c3_reload_done", done_o, 1);
        check("c3_queue", exp_q.size(), 0);

        // Case 4: random source gaps
        pulse_start();
        load_case1(3);
        wait_end();
        check("c4_done", done_o, 1);
        check("c4_queue", exp_q.size(), 0);

        // Case 5: asynchronous reset mid-word
        pulse_start();
        stream = '{8'h00, 8'h02, 8'h8C, 8'h01};
        send_stream(0);
        #3;
        rst_i = 1'b1;
        #1;
        check("c5_async_flags", {imem_we_o, rx_ready_o, cpu_rst_n_o, busy_o, done_o, err_o}, 0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("c5_idle", busy_o, 0);
        pulse_start();
        load_case1(0);
        tick();
        check("c5_reload_done", done_o, 1);
        check("c5_queue", exp_q.size(), 0);

        // Case 6: LEN = DEPTH, full image
        pulse_start();
        stream = '{8'h00, 8'h20};
        send_stream(0);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] w;
            w = 32'hA500_0000 ^ (i * 32'h0102_0304);
            exp_q.push_back({32'(i * 4), w});
            stream = '{w[31:24], w[23:16], w[15:8], w[7:0]};
            send_stream(0);
        end
        wait_end();
        check("c6_done", done_o, 1);
        check("c6_last_addr", imem_addr_o, 32'h0000_007C);
        check("c6_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
